// File: rtl/spc7110_psram_port_if.sv
// Request/return and PSRAM bus signals for the SPC7110 data-ROM read port.
// The slave modport is the port itself; the master side covers the requesters and the PSRAM device.
interface spc7110_psram_port_if;
    logic        dir_req;
    logic [23:0] dir_addr;
    logic        dir_busy;
    logic        dir_valid;
    logic [7:0]  dir_data;
    logic        dcu_req;
    logic [23:0] dcu_addr;
    logic        dcu_busy;
    logic        dcu_valid;
    logic [7:0]  dcu_data;
    logic [22:0] psram_addr;
    logic        psram_ce_n;
    logic        psram_oe_n;
    logic [15:0] psram_data;

    modport slave (
        input  dir_req, dir_addr, dcu_req, dcu_addr, psram_data,
        output dir_busy, dir_valid, dir_data,
        output dcu_busy, dcu_valid, dcu_data,
        output psram_addr, psram_ce_n, psram_oe_n
    );

    modport master (
        output dir_req, dir_addr, dcu_req, dcu_addr, psram_data,
        input  dir_busy, dir_valid, dir_data,
        input  dcu_busy, dcu_valid, dcu_data,
        input  psram_addr, psram_ce_n, psram_oe_n
    );
endinterface

// File: rtl/spc7110_psram_port.sv
// SPC7110 data-ROM read responder: arbitrates direct/DCU byte reads onto a timed
// PSRAM word read, with a one-word cache for repeated reads of the same word.
module spc7110_psram_port #(
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter logic [23:0] PROGROM_SIZE  = 24'h100000
) (
    input logic                CLK,
    input logic                RESET,
    spc7110_psram_port_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] CNT_LOAD  = 4'(ACCESS_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        dir_pend, dcu_pend;
    logic [23:0] dir_slot, dcu_slot;
    logic        owner_dcu, owner_hi;
    logic        cache_valid;
    logic [22:0] cache_tag;
    logic [15:0] cache_word;
    logic [22:0] psram_addr_r;
    logic        ce_n_r, oe_n_r;
    logic        dir_valid_r, dcu_valid_r;
    logic [7:0]  dir_data_r, dcu_data_r;

    logic [23:0] sel_addr, eff;
    logic [22:0] sel_word;
    logic        sel_hi, hit;
    logic [7:0]  hit_byte, rd_byte;

    // Direct slot always takes priority over the DCU slot.
    always_comb begin
        sel_addr = dir_pend ? dir_slot : dcu_slot;
        eff      = sel_addr + PROGROM_SIZE;
        sel_word = eff[23:1];
        sel_hi   = eff[0];
        hit      = cache_valid && (cache_tag == sel_word);
        hit_byte = sel_hi ? cache_word[15:8] : cache_word[7:0];
        rd_byte  = owner_hi ? bus.psram_data[15:8] : bus.psram_data[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dir_pend     <= 1'b0;
            dcu_pend     <= 1'b0;
            dir_slot     <= '0;
            dcu_slot     <= '0;
            owner_dcu    <= 1'b0;
            owner_hi     <= 1'b0;
            cache_valid  <= 1'b0;
            cache_tag    <= '0;
            cache_word   <= '0;
            psram_addr_r <= '0;
            ce_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            dir_valid_r  <= 1'b0;
            dcu_valid_r  <= 1'b0;
            dir_data_r   <= '0;
            dcu_data_r   <= '0;
        end else begin
            dir_valid_r <= 1'b0;
            dcu_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dir_pend || dcu_pend) begin
                        if (hit) begin
                            if (dir_pend) begin
                                dir_valid_r <= 1'b1;
                                dir_data_r  <= hit_byte;
                                dir_pend    <= 1'b0;
                            end else begin
                                dcu_valid_r <= 1'b1;
                                dcu_data_r  <= hit_byte;
                                dcu_pend    <= 1'b0;
                            end
                        end else begin
                            psram_addr_r <= sel_word;
                            ce_n_r       <= 1'b0;
                            oe_n_r       <= 1'b0;
                            cnt          <= CNT_LOAD;
                            owner_dcu    <= !dir_pend;
                            owner_hi     <= sel_hi;
                            state        <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Valid/busy are registered on entry to DONE so they show during DONE.
                    if (cnt == '0) begin
                        cache_word  <= bus.psram_data;
                        cache_tag   <= psram_addr_r;
                        cache_valid <= 1'b1;
                        ce_n_r      <= 1'b1;
                        oe_n_r      <= 1'b1;
                        state       <= ST_DONE;
                        if (owner_dcu) begin
                            dcu_valid_r <= 1'b1;
                            dcu_data_r  <= rd_byte;
                            dcu_pend    <= 1'b0;
                        end else begin
                            dir_valid_r <= 1'b1;
                            dir_data_r  <= rd_byte;
                            dir_pend    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // A slot only fills while empty, so this never collides with the clears above.
            if (bus.dir_req && !dir_pend) begin
                dir_pend <= 1'b1;
                dir_slot <= bus.dir_addr;
            end
            if (bus.dcu_req && !dcu_pend) begin
                dcu_pend <= 1'b1;
                dcu_slot <= bus.dcu_addr;
            end
        end
    end

    assign bus.dir_busy   = dir_pend;
    assign bus.dcu_busy   = dcu_pend;
    assign bus.dir_valid  = dir_valid_r;
    assign bus.dcu_valid  = dcu_valid_r;
    assign bus.dir_data   = dir_data_r;
    assign bus.dcu_data   = dcu_data_r;
    assign bus.psram_addr = psram_addr_r;
    assign bus.psram_ce_n = ce_n_r;
    assign bus.psram_oe_n = oe_n_r;
endmodule

// File: tb/tb_spc7110_psram_port.sv
// Bench for spc7110_psram_port: hand-computed vector table, directed multi-cycle
// sequences, and random traffic against a transaction-level timing/cache model.
module tb_spc7110_psram_port;
    localparam int AC = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   oe_bad = 0;

    spc7110_psram_port_if bus();

    spc7110_psram_port #(.ACCESS_CYCLES(AC), .PROGROM_SIZE(24'h100000)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // PSRAM contents: one fixed word for the first test-plan case, a simple pattern elsewhere.
    function automatic logic [15:0] mem_word(input logic [22:0] a);
        if (a == 23'h080000) return 16'hA55A;
        return {a[7:0] ^ 8'hC3, a[15:8] ^ a[7:0]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [23:0] addr);
        logic [23:0] e;
        logic [15:0] w;
        e = addr + 24'h100000;
        w = mem_word(e[23:1]);
        return e[0] ? w[15:8] : w[7:0];
    endfunction

    assign bus.psram_data = mem_word(bus.psram_addr);

    int          dv_cyc[$], dcv_cyc[$], ce_cyc[$];
    logic [7:0]  dv_dat[$], dcv_dat[$];
    logic [22:0] ce_addr[$];

    always @(negedge CLK) begin
        if (bus.dir_valid) begin dv_cyc.push_back(cyc); dv_dat.push_back(bus.dir_data); end
        if (bus.dcu_valid) begin dcv_cyc.push_back(cyc); dcv_dat.push_back(bus.dcu_data); end
        if (!bus.psram_ce_n) begin ce_cyc.push_back(cyc); ce_addr.push_back(bus.psram_addr); end
        if (bus.psram_ce_n !== bus.psram_oe_n) oe_bad++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        dv_cyc.delete(); dv_dat.delete(); dcv_cyc.delete(); dcv_dat.delete();
        ce_cyc.delete(); ce_addr.delete();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        clear_q();
    endtask

    task automatic issue(input bit d, input bit c, input logic [23:0] da, input logic [23:0] ca,
                         output int t);
        t = cyc;
        bus.dir_req = d; bus.dir_addr = da;
        bus.dcu_req = c; bus.dcu_addr = ca;
        tick();
        bus.dir_req = 1'b0;
        bus.dcu_req = 1'b0;
    endtask

    task automatic wait_for(input bit is_dcu, input string nm, output int vc, output logic [7:0] d);
        int n = 0;
        while (((is_dcu ? dcv_cyc.size() : dv_cyc.size()) == 0) && n < 60) begin
            tick();
            n++;
        end
        if ((is_dcu ? dcv_cyc.size() : dv_cyc.size()) == 0) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            vc = -1000;
            d  = 8'h00;
        end else if (is_dcu) begin
            vc = dcv_cyc.pop_front(); d = dcv_dat.pop_front();
        end else begin
            vc = dv_cyc.pop_front(); d = dv_dat.pop_front();
        end
    endtask

    typedef struct {
        bit          is_dcu;
        logic [23:0] addr;
        bit          miss;
        logic [22:0] paddr;
        logic [7:0]  bval;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int t, vc, vc2, bad;
        logic [7:0] d, d2;
        bit m_cv;
        logic [22:0] m_tag;
        int misses;

        tbl[0] = '{1'b0, 24'h000000, 1'b1, 23'h080000, 8'h5A, 6};
        tbl[1] = '{1'b0, 24'h000001, 1'b0, 23'h000000, 8'hA5, 2};
        tbl[2] = '{1'b1, 24'h000000, 1'b0, 23'h000000, 8'h5A, 2};
        tbl[3] = '{1'b0, 24'hFFFFFF, 1'b1, 23'h07FFFF, 8'h3C, 6};
        tbl[4] = '{1'b1, 24'h000010, 1'b1, 23'h080008, 8'h08, 6};
        tbl[5] = '{1'b1, 24'h000011, 1'b0, 23'h000000, 8'hCB, 2};
        tbl[6] = '{1'b0, 24'h000021, 1'b1, 23'h080010, 8'hD3, 6};
        tbl[7] = '{1'b0, 24'h000020, 1'b0, 23'h000000, 8'h10, 2};

        bus.dir_req = 1'b0; bus.dir_addr = '0;
        bus.dcu_req = 1'b0; bus.dcu_addr = '0;
        do_reset();

        check("rst_dir_busy", bus.dir_busy, 0);
        check("rst_dcu_busy", bus.dcu_busy, 0);
        check("rst_dir_valid", bus.dir_valid, 0);
        check("rst_dcu_valid", bus.dcu_valid, 0);
        check("rst_dir_data", bus.dir_data, 0);
        check("rst_dcu_data", bus.dcu_data, 0);
        check("rst_ce_n", bus.psram_ce_n, 1);
        check("rst_oe_n", bus.psram_oe_n, 1);
        check("rst_paddr", bus.psram_addr, 0);

        for (int i = 0; i < 8; i++) begin
            clear_q();
            issue(!tbl[i].is_dcu, tbl[i].is_dcu, tbl[i].addr, tbl[i].addr, t);
            check($sformatf("v%0d_busy", i), tbl[i].is_dcu ? bus.dcu_busy : bus.dir_busy, 1);
            wait_for(tbl[i].is_dcu, $sformatf("v%0d", i), vc, d);
            check($sformatf("v%0d_byte", i), d, tbl[i].bval);
            check($sformatf("v%0d_lat", i), vc - t, tbl[i].lat);
            check($sformatf("v%0d_ce_cycles", i), ce_cyc.size(), tbl[i].miss ? AC : 0);
            if (tbl[i].miss && ce_cyc.size() > 0) begin
                check($sformatf("v%0d_ce_start", i), ce_cyc[0] - t, 2);
                bad = 0;
                foreach (ce_addr[k]) if (ce_addr[k] !== tbl[i].paddr) bad++;
                check($sformatf("v%0d_paddr_bad", i), bad, 0);
            end
            tick();
        end

        // Simultaneous requests: direct first, then DCU.
        do_reset();
        issue(1'b1, 1'b1, 24'h000010, 24'h000020, t);
        check("sim_both_busy", {bus.dir_busy, bus.dcu_busy}, 2'b11);
        wait_for(1'b0, "sim_dir", vc, d);
        wait_for(1'b1, "sim_dcu", vc2, d2);
        check("sim_dir_lat", vc - t, 6);
        check("sim_dir_byte", d, 8'h08);
        check("sim_dcu_lat", vc2 - t, 12);
        check("sim_dcu_byte", d2, 8'h10);
        check("sim_gap", vc2 - vc, 6);
        check("sim_ce_cycles", ce_cyc.size(), 2 * AC);
        if (ce_cyc.size() == 2 * AC) begin
            check("sim_addr0", ce_addr[0], 23'h080008);
            check("sim_addr1", ce_addr[AC], 23'h080010);
            check("sim_ce1_start", ce_cyc[AC] - t, 8);
        end
        repeat (3) tick();
        check("sim_dir_hold", bus.dir_data, 8'h08);

        // DCU in flight, direct arrives three cycles later and must wait.
        do_reset();
        issue(1'b0, 1'b1, 24'h0, 24'h000040, t);
        tick(); tick();
        bus.dir_req = 1'b1; bus.dir_addr = 24'h000080;
        tick();
        bus.dir_req = 1'b0;
        check("np_dir_busy", bus.dir_busy, 1);
        check("np_dcu_busy", bus.dcu_busy, 1);
        wait_for(1'b1, "np_dcu", vc, d);
        wait_for(1'b0, "np_dir", vc2, d2);
        check("np_dcu_lat", vc - t, 6);
        check("np_dcu_byte", d, 8'h20);
        check("np_dir_lat", vc2 - t, 12);
        check("np_dir_byte", d2, 8'h40);
        check("np_ce_cycles", ce_cyc.size(), 2 * AC);
        if (ce_cyc.size() == 2 * AC) begin
            bad = 0;
            for (int k = 0; k < AC; k++) if (ce_addr[k] !== 23'h080020) bad++;
            check("np_dcu_addr_bad", bad, 0);
            check("np_dir_start", ce_cyc[AC] - t, 8);
            check("np_dir_addr", ce_addr[AC], 23'h080040);
        end

        // Reset in the middle of an access.
        do_reset();
        issue(1'b1, 1'b0, 24'h000100, 24'h0, t);
        tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("ra_ce_n", bus.psram_ce_n, 1);
        check("ra_busy", bus.dir_busy, 0);
        repeat (12) tick();
        check("ra_no_valid", dv_cyc.size() + dcv_cyc.size(), 0);
        clear_q();
        issue(1'b1, 1'b0, 24'h000100, 24'h0, t);
        wait_for(1'b0, "ra_again", vc, d);
        check("ra_again_lat", vc - t, 6);
        check("ra_again_ce", ce_cyc.size(), AC);
        check("ra_again_byte", d, exp_byte(24'h000100));

        // Random traffic against a transaction-level model.
        do_reset();
        m_cv = 1'b0; m_tag = '0; misses = 0;
        for (int n = 0; n < 40; n++) begin
            int mode, a, ev[2];
            logic [23:0] ad[2];
            logic [23:0] e;
            bit h;
            mode = $urandom_range(0, 2);
            for (int s = 0; s < 2; s++) begin
                ad[s] = ($urandom_range(0, 7) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15)))
                                                     : 24'($urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 2)) tick();
            issue(mode != 1, mode != 0, ad[0], ad[1], t);
            a = t + 1;
            for (int s = 0; s < 2; s++) begin
                ev[s] = 0;
                if ((s == 0 && mode != 1) || (s == 1 && mode != 0)) begin
                    e = ad[s] + 24'h100000;
                    h = m_cv && (m_tag == e[23:1]);
                    ev[s] = h ? a + 1 : a + 1 + AC;
                    if (!h) begin m_cv = 1'b1; m_tag = e[23:1]; misses++; end
                    a = h ? a + 1 : a + 2 + AC;
                end
            end
            if (mode != 1) begin
                wait_for(1'b0, $sformatf("r%0d_dir", n), vc, d);
                check($sformatf("r%0d_dir_cyc", n), vc, ev[0]);
                check($sformatf("r%0d_dir_byte", n), d, exp_byte(ad[0]));
            end
            if (mode != 0) begin
                wait_for(1'b1, $sformatf("r%0d_dcu", n), vc, d);
                check($sformatf("r%0d_dcu_cyc", n), vc, ev[1]);
                check($sformatf("r%0d_dcu_byte", n), d, exp_byte(ad[1]));
            end
            tick();
        end
        check("rnd_ce_cycles", ce_cyc.size(), misses * AC);
        check("rnd_extra_valid", dv_cyc.size() + dcv_cyc.size(), 0);
        check("oe_follows_ce", oe_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
